// File: rtl/cic_interp.sv
// rtl/cic_interp.sv - N-stage CIC interpolator (M=1) with runtime factor R.
// Define CIC_INTERP_SAT_EN to saturate the output instead of wrapping.
module cic_interp #(
    parameter int DATA_WIDTH = 16,
    parameter int N_STAGES   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4:0]            R,
    input  logic [DATA_WIDTH-1:0] x_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] x_out,
    output logic                  out_valid
);

    localparam int IW = DATA_WIDTH + 5 * N_STAGES;
    localparam int SW = 8;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                state;
    logic [4:0]            r_l;
    logic [4:0]            phase;
    logic [4:0]            r_eff;
    logic                  accept;
    logic                  last_phase;
    logic                  step;

    logic signed [IW-1:0]  comb_dly [N_STAGES];
    logic signed [IW-1:0]  comb_val [N_STAGES+1];
    logic signed [IW-1:0]  comb_reg;
    logic signed [IW-1:0]  integ    [N_STAGES];
    logic signed [IW-1:0]  integ_nx [N_STAGES];
    logic signed [IW-1:0]  integ_in;

    logic                  step_q;
    logic [SW-1:0]         shift_q;
    logic [DATA_WIDTH-1:0] reduced;

    function automatic logic [2:0] flog2(input logic [4:0] r);
        if (r[4])      return 3'd4;
        else if (r[3]) return 3'd3;
        else if (r[2]) return 3'd2;
        else if (r[1]) return 3'd1;
        else           return 3'd0;
    endfunction

    assign r_eff      = (R == 5'd0) ? 5'd1 : R;
    assign accept     = in_valid && in_ready;
    assign last_phase = (phase == r_l - 5'd1);
    assign step       = (state == RUN);

    // Comb section: N first differences evaluated on the incoming sample
    always_comb begin
        comb_val[0] = {{(IW-DATA_WIDTH){x_in[DATA_WIDTH-1]}}, x_in};
        for (int k = 0; k < N_STAGES; k++) begin
            comb_val[k+1] = comb_val[k] - comb_dly[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_STAGES; k++) begin
                comb_dly[k] <= '0;
            end
            comb_reg <= '0;
        end else if (accept) begin
            for (int k = 0; k < N_STAGES; k++) begin
                comb_dly[k] <= comb_val[k];
            end
            comb_reg <= comb_val[N_STAGES];
        end
    end

    // Integrator chain is evaluated combinationally so one step settles all stages
    always_comb begin
        integ_in    = (phase == 5'd0) ? comb_reg : '0;
        integ_nx[0] = integ[0] + integ_in;
        for (int k = 1; k < N_STAGES; k++) begin
            integ_nx[k] = integ[k] + integ_nx[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_STAGES; k++) begin
                integ[k] <= '0;
            end
        end else if (step) begin
            for (int k = 0; k < N_STAGES; k++) begin
                integ[k] <= integ_nx[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            phase    <= '0;
            r_l      <= 5'd1;
            in_ready <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= RUN;
                        phase    <= '0;
                        r_l      <= r_eff;
                        in_ready <= (r_eff == 5'd1);
                    end
                end
                RUN: begin
                    if (last_phase) begin
                        if (accept) begin
                            phase    <= '0;
                            r_l      <= r_eff;
                            in_ready <= (r_eff == 5'd1);
                        end else begin
                            state    <= IDLE;
                            phase    <= '0;
                            in_ready <= 1'b1;
                        end
                    end else begin
                        phase    <= phase + 5'd1;
                        in_ready <= (phase + 5'd2 == r_l);
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef CIC_INTERP_SAT_EN
    logic signed [IW-1:0]        shifted;
    logic [IW-DATA_WIDTH:0]      hi_bits;
    always_comb begin
        shifted = integ[N_STAGES-1] >>> shift_q;
        hi_bits = shifted[IW-1:DATA_WIDTH-1];
        if ((&hi_bits) || !(|hi_bits)) begin
            reduced = shifted[DATA_WIDTH-1:0];
        end else if (shifted[IW-1]) begin
            reduced = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            reduced = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    end
`else
    always_comb begin
        reduced = DATA_WIDTH'(integ[N_STAGES-1] >>> shift_q);
    end
`endif

    // Shift travels with each step so a relatched R_l never affects the previous block
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q    <= 1'b0;
            shift_q   <= '0;
            x_out     <= '0;
            out_valid <= 1'b0;
        end else begin
            step_q    <= step;
            shift_q   <= SW'((N_STAGES - 1) * int'(flog2(r_l)));
            out_valid <= step_q;
            if (step_q) begin
                x_out <= reduced;
            end
        end
    end

endmodule

// File: tb/tb_cic_interp.sv
// tb/tb_cic_interp.sv - scoreboard bench for cic_interp against an arithmetic model.
// Honours CIC_INTERP_SAT_EN for the expected output reduction.
module tb_cic_interp;

    localparam int DW = 16;
    localparam int NS = 3;
    localparam int IW = DW + 5 * NS;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [4:0]    R = 5'd4;
    logic [DW-1:0] x_in = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] x_out;
    logic          out_valid;

    cic_interp #(.DATA_WIDTH(DW), .N_STAGES(NS)) dut (
        .clk(clk), .rst_n(rst_n), .R(R), .x_in(x_in), .in_valid(in_valid),
        .in_ready(in_ready), .x_out(x_out), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_out = 0;

    typedef struct { int val; int cyc; } exp_t;
    typedef struct { bit chk; int val; } cst_t;
    exp_t   exp_q[$];
    cst_t   cst_q[$];
    longint hist[NS+1];
    longint acc[NS];

`ifdef CIC_INTERP_SAT_EN
    localparam int SAT_STEADY = 32767;
`else
    localparam int SAT_STEADY = -28672;
`endif

    task automatic check(string name, longint act, longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic longint wrap_iw(longint v);
        longint m;
        m = v & ((64'sd1 <<< IW) - 1);
        if (m >= (64'sd1 <<< (IW - 1))) m -= (64'sd1 <<< IW);
        return m;
    endfunction

    function automatic longint binom(int n, int k);
        longint c = 1;
        for (int i = 0; i < k; i++) c = c * (n - i) / (i + 1);
        return c;
    endfunction

    function automatic int out_of(longint a, int s);
        longint v;
        int     w;
        v = a >>> s;
`ifdef CIC_INTERP_SAT_EN
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        w = int'(v);
`else
        w = int'(v & 65535);
        if (w > 32767) w -= 65536;
`endif
        return w;
    endfunction

    // Comb output as a binomial difference over input history; integrators as running sums
    task automatic model_accept(int x, int r, int acc_cyc);
        int     rl;
        int     s;
        longint c;
        longint in_v;
        exp_t   e;
        rl = (r == 0) ? 1 : r;
        s  = (NS - 1) * ($clog2(rl + 1) - 1);
        for (int k = NS; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = x;
        c = 0;
        for (int k = 0; k <= NS; k++) c += ((k % 2) ? -1 : 1) * binom(NS, k) * hist[k];
        c = wrap_iw(c);
        for (int p = 0; p < rl; p++) begin
            in_v   = (p == 0) ? c : 0;
            acc[0] = wrap_iw(acc[0] + in_v);
            for (int k = 1; k < NS; k++) acc[k] = wrap_iw(acc[k] + acc[k-1]);
            e.val = out_of(acc[NS-1], s);
            e.cyc = acc_cyc + 2 + p;
            exp_q.push_back(e);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            cst_q.delete();
            for (int k = 0; k <= NS; k++) hist[k] = 0;
            for (int k = 0; k < NS; k++) acc[k] = 0;
        end else if (in_valid && in_ready) begin
            model_accept(int'($signed(x_in)), int'(R), cyc + 1);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        cst_t c;
        if (rst_n) begin
            if (out_valid) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got out_valid=1 x_out=%0d, expected no output (cycle %0d)",
                             $signed(x_out), cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("out_cycle", cyc, e.cyc);
                    check("out_value", $signed(x_out), e.val);
                    if (cst_q.size() > 0) begin
                        c = cst_q.pop_front();
                        if (c.chk) check("directed_value", $signed(x_out), c.val);
                    end
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                total++;
                bad++;
                $display("FAIL missing_out: got out_valid=0, expected x_out=%0d at cycle %0d", exp_q[0].val, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic send(int x, int r);
        int n = 0;
        x_in     = DW'(x);
        R        = 5'(r);
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) check("send_timeout", n, 0);
        @(posedge clk); #1;
    endtask

    task automatic idle(int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drain();
        int n = 0;
        in_valid = 1'b0;
        while (exp_q.size() > 0 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 400) check("drain_timeout", n, 0);
        idle(2);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
    endtask

    task automatic push_cst(bit chk, int val, int count);
        cst_t c;
        c.chk = chk;
        c.val = val;
        repeat (count) cst_q.push_back(c);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int imp[10] = '{1024, 3072, 6144, 10240, 12288, 12288, 10240, 6144, 3072, 1024};
        int pt[3]   = '{100, -200, 300};
        int n0;
        int c0;
        int n;

        #12;
        check("reset_x_out", x_out, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_in_ready", in_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Impulse response; first send follows reset release immediately
        for (int i = 0; i < 10; i++) push_cst(1'b1, imp[i], 1);
        push_cst(1'b1, 0, 10);
        send(16384, 4);
        for (int i = 0; i < 4; i++) send(0, 4);
        drain();

        // DC gain and in_ready cadence
        do_reset();
        push_cst(1'b0, 0, 10);
        push_cst(1'b1, 16384, 30);
        send(16384, 4);
        c0 = cyc;
        for (int i = 0; i < 11; i++) send(16384, 4);
        check("dc_accept_spacing", cyc - c0, 44);
        drain();

        // Overdriven DC at R=3
        do_reset();
        push_cst(1'b0, 0, 9);
        push_cst(1'b1, SAT_STEADY, 30);
        for (int i = 0; i < 14; i++) send(16384, 3);
        drain();

        // Passthrough at R=1
        do_reset();
        for (int i = 0; i < 3; i++) push_cst(1'b1, pt[i], 1);
        for (int i = 0; i < 3; i++) send(pt[i], 1);
        drain();

        // Single R=8 block with R changed mid-block
        n0 = n_out;
        send(5000, 8);
        in_valid = 1'b0;
        R = 5'd2;
        drain();
        check("r8_pulse_count", n_out - n0, 8);
        check("idle_in_ready", in_ready, 1);
        check("idle_out_valid", out_valid, 0);

        // Reset during the third output of an R=8 block
        n0 = n_out;
        send(8000, 8);
        in_valid = 1'b0;
        n = 0;
        while (n_out < n0 + 3 && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        check("reset_wait", n_out - n0, 3);
        rst_n = 1'b0;
        #1;
        check("midreset_x_out", x_out, 0);
        check("midreset_out_valid", out_valid, 0);
        check("midreset_in_ready", in_ready, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(20);
        check("no_out_after_reset", n_out - n0, 3);
        send(-1234, 2);
        drain();

        // Randomised traffic with varying R and gaps
        do_reset();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) < 7) send(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 9)));
            else idle(int'($urandom_range(1, 3)));
        end
        drain();
        check("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cic_interp.md
CIC_INTERP -- requirements
Module: cic_interp

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, giving the sample width of x_in and x_out (signed s16.15 at default).
REQ-002 SHALL have parameter N_STAGES, default 3, giving the number of comb stages and the number of integrator stages; differential delay M is fixed at 1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port R, input, 5 bits: interpolation factor 1..31; the value 0 SHALL be treated as 1.
REQ-006 SHALL have port x_in, input, DATA_WIDTH bits: signed low-rate input sample.
REQ-007 SHALL have port in_valid, input, 1 bit: x_in is valid this cycle.
REQ-008 SHALL have port in_ready, output, 1 bit: the block accepts x_in this cycle.
REQ-009 SHALL have port x_out, output, DATA_WIDTH bits: signed high-rate output sample.
REQ-010 SHALL have port out_valid, output, 1 bit: x_out holds a new sample this cycle.

Function
REQ-011 An input SHALL be accepted on a rising edge where in_valid and in_ready are both 1; no other edge SHALL change the comb state.
REQ-012 The effective factor R_l SHALL be latched on each accept; changes to R between accepts SHALL have no effect on the current block.
REQ-013 The comb section SHALL apply N_STAGES first differences (M=1) at the input rate; the comb state SHALL update only on accepts.
REQ-014 Each accept SHALL produce exactly R_l integrator steps. The first step's input SHALL be the comb output; the remaining R_l-1 steps SHALL have zero input (zero-stuffing).
REQ-015 Internal width SHALL be IW = DATA_WIDTH + 5*N_STAGES. Integrators SHALL wrap modulo 2^IW, so no overflow handling is needed.
REQ-016 The output SHALL be the last integrator value arithmetically right-shifted by S = (N_STAGES-1)*floor(log2(R_l)), then reduced to DATA_WIDTH per REQ-027/028.
REQ-017 The first out_valid SHALL be asserted 2 clock cycles after the accepting edge. out_valid SHALL be 1 for one cycle per integrator step and 0 otherwise.
REQ-018 A control FSM SHALL have states IDLE and RUN. IDLE goes to RUN on an accept. RUN goes to IDLE when the last phase completes with no pending accept. RUN stays in RUN when an accept coincides with the last phase.
REQ-019 in_ready SHALL be 1 in IDLE. In RUN, in_ready SHALL be 1 only in the cycle where accepting gives gap-free continuation. With in_valid held at 1, out_valid SHALL stay continuously 1 and in_ready SHALL pulse once every R_l cycles.
REQ-020 On underrun (last phase done, in_valid=0), integrators SHALL hold their value, out_valid SHALL be 0, x_out SHALL hold its value, and the FSM SHALL return to IDLE.
REQ-021 With R_l=1, the block SHALL output the input unchanged with 2-cycle latency, one output per accept.

Reset
REQ-022 rst_n=0 SHALL asynchronously clear all comb and integrator registers, the phase counter and R_l (R_l becomes 1).
REQ-023 During reset, x_out SHALL be 0, out_valid 0, the FSM in IDLE, and in_ready 1.
REQ-024 Reset asserted mid-block SHALL abandon the block; no further out_valid for that block SHALL appear after release.
REQ-025 After rst_n rises, the first accept SHALL be possible on the next rising edge.

Configuration
REQ-026 The macro CIC_INTERP_SAT_EN SHALL select output saturation.
REQ-027 With CIC_INTERP_SAT_EN defined, a shifted value above 2^(DATA_WIDTH-1)-1 SHALL clamp to that maximum, and a value below -2^(DATA_WIDTH-1) SHALL clamp to that minimum.
REQ-028 Without CIC_INTERP_SAT_EN, the output SHALL be the low DATA_WIDTH bits of the shifted value (two's-complement wrap).

Verification
REQ-029 Impulse test: R=4, accept 16384 then continuous zeros. x_out SHALL be 1024, 3072, 6144, 10240, 12288, 12288, 10240, 6144, 3072, 1024, then 0.
REQ-030 DC test: R=4, continuous 16384 inputs. After 10 outputs, x_out SHALL be steady at 16384 with out_valid continuously 1 and in_ready pulsing every 4th cycle.
REQ-031 Saturation test: R=3, continuous 16384 inputs. The steady value SHALL be 32767 with the macro, and -28672 without it.
REQ-032 Passthrough test: R=1, inputs 100, -200, 300. x_out SHALL be 100, -200, 300, each 2 cycles after its accept.
REQ-033 Underrun and R-change test: R=8 with a single accept. SHALL give exactly 8 out_valid pulses, then IDLE with out_valid 0. Changing R to 2 mid-block SHALL not alter the pulse count.
REQ-034 Reset test: assert rst_n=0 during the 3rd output of an R=8 block. Outputs SHALL clear immediately and no further out_valid SHALL occur until a new accept.
